// File: rtl/stride_commutator_if.sv
// Bus bundle for stride_commutator: input handshake, flush request and
// registered output pair. slave = commutator side, master = feeding stage.
interface stride_commutator_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_0;
  logic [DATA_WIDTH-1:0] in_1;
  logic                  flush;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_0;
  logic [DATA_WIDTH-1:0] out_1;

  modport slave (
    input  in_valid, in_0, in_1, flush,
    output in_ready, out_valid, out_0, out_1
  );

  modport master (
    output in_valid, in_0, in_1, flush,
    input  in_ready, out_valid, out_0, out_1
  );
endinterface

// File: rtl/stride_commutator.sv
// 2-lane stride commutator: lane-1 pre-delay, 2x2 crossbar steered by the
// beat counter MSB, lane-0 post-delay, registered output pair.
// Optional sticky protocol error output enabled by STRIDE_COMMUTATOR_ERR_EN.

// DEPTH-deep shift register advancing only on internal beats.
module sc_dly #(
  parameter int W = 64,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [N-1:0][W-1:0] sr;

  // shift one slot per internal beat; reset wipes buffered data
  always_ff @(posedge clk) begin
    if (!rst_n) sr <= '0;
    else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[N-1];
endmodule

module stride_commutator #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stride_commutator_if.slave     bus
`ifdef STRIDE_COMMUTATOR_ERR_EN
  ,
  output logic                   err
`endif
);
  localparam int LG = $clog2(DEPTH);
  localparam int CW = LG + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         cnt, fill, dcnt;
  logic                  acc, drn, ib, ctrl;
  logic [DATA_WIDTH-1:0] x0, x1, a1, b0, b1, b0d;
  logic                  ov;
  logic [DATA_WIDTH-1:0] o0, o1;

  assign drn  = (state == S_DRAIN);
  assign bus.in_ready = !drn;
  assign acc  = bus.in_valid && !drn;
  assign ib   = acc || drn;
  assign x0   = drn ? '0 : bus.in_0;
  assign x1   = drn ? '0 : bus.in_1;
  assign ctrl = cnt[LG];

  sc_dly #(.W(DATA_WIDTH), .N(DEPTH)) u_dl1 (
    .clk(clk), .rst_n(rst_n), .en(ib), .d(x1), .q(a1)
  );

  // crossbar: straight in the first half-block, swapped in the second
  assign b0 = ctrl ? a1 : x0;
  assign b1 = ctrl ? x0 : a1;

  sc_dly #(.W(DATA_WIDTH), .N(DEPTH)) u_dl0 (
    .clk(clk), .rst_n(rst_n), .en(ib), .d(b0), .q(b0d)
  );

  // block sequencing: fill D beats, run, drain D zero beats on flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FILL;
      cnt   <= '0;
      fill  <= '0;
      dcnt  <= '0;
    end else begin
      if (ib) cnt <= cnt + 1'b1;
      case (state)
        S_FILL: if (acc) begin
          fill <= fill + 1'b1;
          if (fill == LAST) state <= S_RUN;
        end
        S_RUN: if (bus.flush && cnt == '0) begin
          state <= S_DRAIN;
          dcnt  <= '0;
        end
        S_DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == LAST) begin
            state <= S_FILL;
            cnt   <= '0;
            fill  <= '0;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  // output stage: capture the pair on every internal beat past fill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ov <= 1'b0;
      o0 <= '0;
      o1 <= '0;
    end else begin
      ov <= ib && (state != S_FILL);
      if (ib && state != S_FILL) begin
        o0 <= b0d;
        o1 <= b1;
      end
    end
  end

  assign bus.out_valid = ov;
  assign bus.out_0     = o0;
  assign bus.out_1     = o1;

`ifdef STRIDE_COMMUTATOR_ERR_EN
  logic flush_q;

  // sticky error: beat offered while draining, or flush withdrawn unhonored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err     <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= bus.flush;
      if ((bus.in_valid && drn) || (state == S_RUN && flush_q && !bus.flush))
        err <= 1'b1;
    end
  end
`endif
endmodule
